hilo_muldiv: RTL
================

Name: hilo_muldiv

Overview:
Iterative multiply/divide unit that owns the HI/LO register pair for the MIPS pipeline. It consumes forwarded rs/rt operands from the execute stage when a mult/multu/div/divu issues, then runs a multi-cycle radix-2 algorithm. While busy it raises a stall to the hazard logic. It also serves mthi/mtlo writes and supplies hi/lo to mfhi/mflo.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits, the product is 2*WIDTH bits.
CNT_W, 5, iteration counter width; must equal log2(WIDTH).

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  issue a mult/div; sampled only in IDLE.
op  input  2  00 mult, 01 multu, 10 div, 11 divu.
rs_value  input  WIDTH  forwarded rs operand (dividend or multiplicand).
rt_value  input  WIDTH  forwarded rt operand (divisor or multiplier).
mthi  input  1  write wdata to HI.
mtlo  input  1  write wdata to LO.
mf_req  input  1  an mfhi/mflo is in the execute stage.
wdata  input  WIDTH  forwarded rs value for mthi/mtlo.
flush  input  1  cancel the in-flight operation.
busy  output  1  high in RUN or FIX.
stall  output  1  busy & (start | mthi | mtlo | mf_req); combinational.
done  output  1  one-cycle pulse when HI/LO are updated, or when a divide-by-zero is reported.
div_zero  output  1  one-cycle pulse, coincident with done, for div/divu with rt_value==0.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, reset_n low): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, div_zero=0. Reset mid-operation aborts it and leaves no partial result.
- FSM states: IDLE, RUN, FIX.
- IDLE, start=1, flush=0:
  - Latch operand magnitudes; signed ops take the absolute value of negative operands.
  - Record result sign: quotient/product sign = sign(rs)^sign(rt); remainder sign = sign(rs). Unsigned ops record sign 0.
  - counter=0; go to RUN.
- IDLE, start=1, op is div/divu, rt_value==0:
  - Stay in IDLE.
  - Next cycle done=1 and div_zero=1.
  - hi/lo unchanged.
- RUN: one iteration per edge, counter increments each edge. On the edge where counter==WIDTH-1, go to FIX.
  - Multiply: shift-add. If the multiplier LSB is set, add the multiplicand into the upper accumulator half, then shift the 2*WIDTH accumulator right by 1 with carry-in.
  - Divide: restoring. Shift {rem,quot} left 1, trial-subtract the divisor from rem. If non-negative, keep the difference and set quot LSB=1.
- FIX (one edge):
  - Apply sign correction by two's-complement negation where the recorded sign is 1.
  - mult/multu: {hi,lo} = 64-bit product.
  - div/divu: lo = quotient, hi = remainder.
  - Set done=1 for the following cycle, drop busy, return to IDLE.
- Latency: start sampled at edge 0; RUN occupies edges 1..32; FIX at edge 33; done and the new hi/lo are visible after edge 33.
- Arithmetic wrap: signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. Magnitudes are held in WIDTH+1 bits internally so the absolute value of 0x80000000 is exact.
- mthi/mtlo in IDLE: write hi/lo at the next edge.
- Start, mthi/mtlo and mf_req while busy:
  - mthi/mtlo and start are ignored, and stall holds the pipeline so they re-present after done.
  - mf_req also stalls.
- start and mthi/mtlo asserted together in IDLE: start wins; the mt write is dropped.
- flush, synchronous:
  - In RUN/FIX: go to IDLE, busy=0, no done, hi/lo unchanged.
  - In IDLE with start: start is ignored.
  - flush overrides the FIX write on the same edge.
- done and div_zero are never asserted for more than one cycle.

Optional Feature:
HILO_FAST_MUL_EN defined:
- mult/multu compute the full product combinationally at the start edge and skip RUN (IDLE→FIX directly).
- done appears after edge 1.
- Division is unchanged.

Not defined:
- Multiplies are iterative with the same 33-edge latency as divides.

Test Plan:
- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF → busy for 33 edges, done pulse, hi=0xFFFFFFFE, lo=0x00000001; latency 2 with HILO_FAST_MUL_EN.
- div rs=0xFFFFFFF9 (-7), rt=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); div rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
- divu rs=5, rt=0 with hi=0x11, lo=0x22 → next cycle done=1 and div_zero=1, busy never high, hi/lo stay 0x11/0x22.
- mult 3*-4 started, flush at edge 10 → busy low after edge 10, no done, hi/lo unchanged; a new start next cycle completes normally (hi=0xFFFFFFFF, lo=0xFFFFFFF4).
- divu in flight, mthi=1 wdata=0xABCD and mf_req=1 → stall=1 until done; the mthi presented after done sets hi=0xABCD.
- reset_n low at edge 20 of a div → immediately hi=lo=0, busy=0; no done after reset release.

Source files
------------

// File: rtl/hilo_muldiv.sv
// ---------------------------------------------------------------------------
// hilo_muldiv
//
// Iterative multiply/divide unit that owns the MIPS HI/LO register pair.
// A mult/multu/div/divu is issued from IDLE with forwarded rs/rt operands.
// The unit then runs a radix-2 shift-add multiply or restoring divide on
// operand magnitudes for WIDTH iterations (RUN). It applies the sign
// correction and writes HI/LO in a single FIX cycle. While busy it stalls
// any new start, mthi/mtlo or mfhi/mflo in the execute stage.
//
// Optional build macro:
//   HILO_FAST_MUL_EN - multiplies are computed combinationally at the
//                      start edge and go straight from IDLE to FIX.
//                      Divides stay iterative.
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   issue mult/div (sampled only in IDLE)
//   op         in   00 mult, 01 multu, 10 div, 11 divu
//   rs_value   in   dividend / multiplicand
//   rt_value   in   divisor / multiplier
//   mthi       in   write wdata into HI
//   mtlo       in   write wdata into LO
//   mf_req     in   mfhi/mflo present in execute
//   wdata      in   forwarded rs value for mthi/mtlo
//   flush      in   cancel the in-flight operation
//   busy       out  operation in progress (RUN or FIX)
//   stall      out  busy and a HI/LO consumer or producer is waiting
//   done       out  one-cycle pulse when HI/LO updated or div-by-zero
//   div_zero   out  one-cycle pulse with done for divide by zero
//   hi         out  HI register
//   lo         out  LO register
// ---------------------------------------------------------------------------
module hilo_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_value,
    input  logic [WIDTH-1:0] rt_value,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             mf_req,
    input  logic [WIDTH-1:0] wdata,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               isDiv_q, isDiv_d;
    logic               negQuot_q, negQuot_d;
    logic               negRem_q, negRem_d;
    // operand_q holds the multiplicand or the divisor magnitude.
    // accHi_q/accLo_q form the product accumulator or the {rem, quot} pair.
    logic [WIDTH:0]     operand_q, operand_d;
    logic [WIDTH:0]     accHi_q, accHi_d;
    logic [WIDTH-1:0]   accLo_q, accLo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               divZero_q, divZero_d;

    logic               rsNeg, rtNeg;
    logic [WIDTH:0]     rsMag, rtMag;

    logic [WIDTH:0]     divShift;
    logic [WIDTH+1:0]   divDiff;
    logic               divOk;
    logic [WIDTH:0]     divHiNext;
    logic [WIDTH-1:0]   divLoNext;

    logic [2*WIDTH-1:0] productMag;
    logic [2*WIDTH-1:0] productRes;
    logic [WIDTH-1:0]   remMag;
    logic [WIDTH-1:0]   quotRes, remRes;

    // Operand magnitudes. One extra bit keeps |0x80000000| exact.
    assign rsNeg = ~op[0] & rs_value[WIDTH-1];
    assign rtNeg = ~op[0] & rt_value[WIDTH-1];
    assign rsMag = rsNeg ? ({1'b0, ~rs_value} + (WIDTH+1)'(1)) : {1'b0, rs_value};
    assign rtMag = rtNeg ? ({1'b0, ~rt_value} + (WIDTH+1)'(1)) : {1'b0, rt_value};

    // One restoring-divide step: shift {rem,quot} left, trial-subtract.
    assign divShift  = {accHi_q[WIDTH-1:0], accLo_q[WIDTH-1]};
    assign divDiff   = {1'b0, divShift} - {1'b0, operand_q};
    assign divOk     = ~divDiff[WIDTH+1];
    assign divHiNext = divOk ? divDiff[WIDTH:0] : divShift;
    assign divLoNext = {accLo_q[WIDTH-2:0], divOk};

`ifdef HILO_FAST_MUL_EN
    logic [2*WIDTH-1:0] fastProd;

    // Full magnitude product, captured at the start edge.
    assign fastProd = {{WIDTH{1'b0}}, rsMag[WIDTH-1:0]} * {{WIDTH{1'b0}}, rtMag[WIDTH-1:0]};
`else
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     mulHiNext;
    logic [WIDTH-1:0]   mulLoNext;

    // One shift-add step. The carry of the add is shifted back into the
    // upper half, so accHi_q[WIDTH] is always zero between steps.
    assign mulSum    = accHi_q + (accLo_q[0] ? operand_q : '0);
    assign mulHiNext = {1'b0, mulSum[WIDTH:1]};
    assign mulLoNext = {mulSum[0], accLo_q[WIDTH-1:1]};
`endif

    // Sign correction applied in FIX.
    assign productMag = {accHi_q[WIDTH-1:0], accLo_q};
    assign productRes = negQuot_q ? (~productMag + (2*WIDTH)'(1)) : productMag;
    assign remMag     = accHi_q[WIDTH-1:0];
    assign quotRes    = negQuot_q ? (~accLo_q + WIDTH'(1)) : accLo_q;
    assign remRes     = negRem_q  ? (~remMag + WIDTH'(1)) : remMag;

    // Next-state logic. An mt write is dropped when start is present in
    // IDLE. flush cancels RUN/FIX, including the FIX write on that edge.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        isDiv_d   = isDiv_q;
        negQuot_d = negQuot_q;
        negRem_d  = negRem_q;
        operand_d = operand_q;
        accHi_d   = accHi_q;
        accLo_d   = accLo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divZero_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!flush) begin
                        if (op[1] && (rt_value == '0)) begin
                            done_d    = 1'b1;
                            divZero_d = 1'b1;
                        end else begin
                            isDiv_d   = op[1];
                            negQuot_d = rsNeg ^ rtNeg;
                            negRem_d  = rsNeg;
                            count_d   = '0;
                            if (op[1]) begin
                                operand_d = rtMag;
                                accHi_d   = '0;
                                accLo_d   = rsMag[WIDTH-1:0];
                                state_d   = RUN;
                            end else begin
`ifdef HILO_FAST_MUL_EN
                                accHi_d = {1'b0, fastProd[2*WIDTH-1:WIDTH]};
                                accLo_d = fastProd[WIDTH-1:0];
                                state_d = FIX;
`else
                                operand_d = rsMag;
                                accHi_d   = '0;
                                accLo_d   = rtMag[WIDTH-1:0];
                                state_d   = RUN;
`endif
                            end
                        end
                    end
                end else begin
                    if (mthi) begin
                        hi_d = wdata;
                    end
                    if (mtlo) begin
                        lo_d = wdata;
                    end
                end
            end

            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    count_d = count_q + CNT_W'(1);
`ifdef HILO_FAST_MUL_EN
                    accHi_d = divHiNext;
                    accLo_d = divLoNext;
`else
                    if (isDiv_q) begin
                        accHi_d = divHiNext;
                        accLo_d = divLoNext;
                    end else begin
                        accHi_d = mulHiNext;
                        accLo_d = mulLoNext;
                    end
`endif
                    if (count_q == CNT_W'(WIDTH-1)) begin
                        state_d = FIX;
                    end
                end
            end

            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (isDiv_q) begin
                        lo_d = quotRes;
                        hi_d = remRes;
                    end else begin
                        hi_d = productRes[2*WIDTH-1:WIDTH];
                        lo_d = productRes[WIDTH-1:0];
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset abandons any partial result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            isDiv_q   <= 1'b0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            operand_q <= '0;
            accHi_q   <= '0;
            accLo_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divZero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            isDiv_q   <= isDiv_d;
            negQuot_q <= negQuot_d;
            negRem_q  <= negRem_d;
            operand_q <= operand_d;
            accHi_q   <= accHi_d;
            accLo_q   <= accLo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            divZero_q <= divZero_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign stall    = busy & (start | mthi | mtlo | mf_req);
    assign done     = done_q;
    assign div_zero = divZero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
